// File: rtl/noc_pkg.sv
// noc_pkg: constants and types shared by the router node blocks of the 2x2 NoC.
//   DATA_WIDTH       default flit width
//   TAIL_BIT/HEAD_BIT/DST_LSB  flit field positions (dst_x at DST_LSB, dst_y above it)
//   DIR_W..DIR_L     output link index, also used by the input arbiter
//   state_e          output controller FSM states
//   dir_onehot()     direction index -> one-hot link vector (bit i = direction i)
package noc_pkg;

    localparam int DATA_WIDTH = 37;

    localparam int TAIL_BIT = 4;
    localparam int HEAD_BIT = 5;
    localparam int DST_LSB  = 6;

    localparam int NUM_DIRS = 5;

    localparam logic [2:0] DIR_W = 3'd0;
    localparam logic [2:0] DIR_S = 3'd1;
    localparam logic [2:0] DIR_E = 3'd2;
    localparam logic [2:0] DIR_N = 3'd3;
    localparam logic [2:0] DIR_L = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_REQ   = 3'd3,
        ST_REL   = 3'd4
    } state_e;

    function automatic logic [NUM_DIRS-1:0] dir_onehot(input logic [2:0] dir);
        logic [NUM_DIRS-1:0] oh;
        case (dir)
            DIR_W:   oh = 5'b00001;
            DIR_S:   oh = 5'b00010;
            DIR_E:   oh = 5'b00100;
            DIR_N:   oh = 5'b01000;
            DIR_L:   oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/xy_route.sv
// xy_route: combinational XY (dimension-ordered) route selection for one node.
// X is resolved first, then Y; a destination equal to this node goes Local.
//   dst_x_i  in  COORD_W  destination X coordinate
//   dst_y_i  in  COORD_W  destination Y coordinate
//   dir_o    out 3        output direction (DIR_W..DIR_L)
module xy_route #(
    parameter int COORD_W = 1,
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0
) (
    input  logic [COORD_W-1:0] dst_x_i,
    input  logic [COORD_W-1:0] dst_y_i,
    output logic [2:0]         dir_o
);
    import noc_pkg::*;

    localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

    // Unsigned compares: coordinates are plain mesh indices.
    always_comb begin
        dir_o = DIR_L;
        if (dst_x_i > MY_X_C) begin
            dir_o = DIR_E;
        end else if (dst_x_i < MY_X_C) begin
            dir_o = DIR_W;
        end else if (dst_y_i > MY_Y_C) begin
            dir_o = DIR_S;
        end else if (dst_y_i < MY_Y_C) begin
            dir_o = DIR_N;
        end
    end

endmodule

// File: rtl/out_port_ctrl.sv
// out_port_ctrl: output-side wormhole scheduler for one router node.
// Pops flits from the node input FIFO, XY-routes head flits, holds the chosen
// output link locked until the tail flit, and forwards each flit over a
// four-phase req/ack link.
//   clk, reset            clock; asynchronous active-high reset
//   empty, q              FIFO empty flag and read data (valid the cycle after rdreq)
//   rdreq                 FIFO pop pulse
//   DataOut               flit shared by all output links
//   Outr_{L,N,E,S,W}      link requests (at most one high)
//   Outw_{L,N,E,S,W}      link acknowledges from downstream
//   busy                  a packet route is open (head sent, tail not yet sent)
//   drop                  pulse when an unrouted non-head flit is discarded
//   dbg_state_o           current FSM state
//
// Link handshake (four-phase): Outr rises with DataOut valid; DataOut and Outr
// hold until the locked link's Outw is sampled high; Outr then falls and the
// controller waits for that Outw to be sampled low before taking the next flit.
module out_port_ctrl #(
    parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH,
    parameter int COORD_W    = 1,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  rdreq,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Outr_L,
    output logic                  Outr_N,
    output logic                  Outr_E,
    output logic                  Outr_S,
    output logic                  Outr_W,
    input  logic                  Outw_L,
    input  logic                  Outw_N,
    input  logic                  Outw_E,
    input  logic                  Outw_S,
    input  logic                  Outw_W,
    output logic                  busy,
    output logic                  drop,
    output noc_pkg::state_e       dbg_state_o
);
    import noc_pkg::*;

    state_e                state_q,    state_d;
    logic                  rdreq_q,    rdreq_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic [NUM_DIRS-1:0]   outr_q,     outr_d;
    logic [2:0]            lock_dir_q, lock_dir_d;
    logic                  locked_q,   locked_d;
    logic                  busy_q,     busy_d;
    logic                  drop_q,     drop_d;

    logic [2:0]            route_dir;
    logic [NUM_DIRS-1:0]   outw_v;
    logic                  ack_sel;
    logic                  q_head;
    logic                  q_tail;

    xy_route #(
        .COORD_W (COORD_W),
        .MY_X    (MY_X),
        .MY_Y    (MY_Y)
    ) u_route (
        .dst_x_i (q[DST_LSB +: COORD_W]),
        .dst_y_i (q[DST_LSB + COORD_W +: COORD_W]),
        .dir_o   (route_dir)
    );

    assign q_head = q[HEAD_BIT];
    assign q_tail = q[TAIL_BIT];

    // Bit i of the vector is direction i, matching dir_onehot().
    assign outw_v  = {Outw_L, Outw_N, Outw_E, Outw_S, Outw_W};
    // Only the locked link's acknowledge matters; the rest are ignored.
    assign ack_sel = |(outw_v & dir_onehot(lock_dir_q));

    always_comb begin
        state_d    = state_q;
        rdreq_d    = 1'b0;
        data_d     = data_q;
        outr_d     = outr_q;
        lock_dir_d = lock_dir_q;
        locked_d   = locked_q;
        busy_d     = busy_q;
        drop_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    rdreq_d = 1'b1;
                    state_d = ST_READ;
                end
            end

            ST_READ: begin
                state_d = ST_LATCH;
            end

            ST_LATCH: begin
                data_d = q;
                if (q_head) begin
                    // A head always re-routes, even over a lock left by a
                    // packet whose tail never arrived.
                    lock_dir_d = route_dir;
                    locked_d   = 1'b1;
                    busy_d     = !q_tail;
                    outr_d     = dir_onehot(route_dir);
                    state_d    = ST_REQ;
                end else if (locked_q) begin
                    outr_d  = dir_onehot(lock_dir_q);
                    state_d = ST_REQ;
                end else begin
                    drop_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (ack_sel) begin
                    outr_d  = '0;
                    state_d = ST_REL;
                end
            end

            ST_REL: begin
                if (!ack_sel) begin
                    if (data_q[TAIL_BIT]) begin
                        locked_d = 1'b0;
                        busy_d   = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rdreq_q    <= 1'b0;
            data_q     <= '0;
            outr_q     <= '0;
            lock_dir_q <= DIR_W;
            locked_q   <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdreq_q    <= rdreq_d;
            data_q     <= data_d;
            outr_q     <= outr_d;
            lock_dir_q <= lock_dir_d;
            locked_q   <= locked_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign rdreq       = rdreq_q;
    assign DataOut     = data_q;
    assign Outr_W      = outr_q[DIR_W];
    assign Outr_S      = outr_q[DIR_S];
    assign Outr_E      = outr_q[DIR_E];
    assign Outr_N      = outr_q[DIR_N];
    assign Outr_L      = outr_q[DIR_L];
    assign busy        = busy_q;
    assign drop        = drop_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_out_port_ctrl.sv
// tb_out_port_ctrl: directed and randomized bench for out_port_ctrl.
// Node sits at (1,1) with 2-bit coordinates so all five links are reachable.
module tb_out_port_ctrl;
    import noc_pkg::*;

    localparam int DW = 37;
    localparam int CW = 2;
    localparam int MX = 1;
    localparam int MY = 1;
    localparam int EW = DW + 5;  // {is_drop, busy, dir[2:0], flit}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          empty;
    logic [DW-1:0] q = '0;
    logic          rdreq;
    logic [DW-1:0] DataOut;
    logic          Outr_L, Outr_N, Outr_E, Outr_S, Outr_W;
    logic          busy, drop;
    state_e        dbg_state;
    logic [4:0]    outw_v = '0;
    logic          spur_n;
    logic [4:0]    outr_v;

    assign outr_v = {Outr_L, Outr_N, Outr_E, Outr_S, Outr_W};

    out_port_ctrl #(
        .DATA_WIDTH (DW),
        .COORD_W    (CW),
        .MY_X       (MX),
        .MY_Y       (MY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .empty       (empty),
        .q           (q),
        .rdreq       (rdreq),
        .DataOut     (DataOut),
        .Outr_L      (Outr_L),
        .Outr_N      (Outr_N),
        .Outr_E      (Outr_E),
        .Outr_S      (Outr_S),
        .Outr_W      (Outr_W),
        .Outw_L      (outw_v[4]),
        .Outw_N      (outw_v[3] | spur_n),
        .Outw_E      (outw_v[2]),
        .Outw_S      (outw_v[1]),
        .Outw_W      (outw_v[0]),
        .busy        (busy),
        .drop        (drop),
        .dbg_state_o (dbg_state)
    );

    // ---------------- FIFO model ----------------
    logic [DW-1:0] fifo_mem [0:1023];
    logic [DW-1:0] pop_log  [0:1023];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int pop_cnt = 0;

    assign empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rdreq && !reset && rd_ptr != wr_ptr) begin
            q                <= fifo_mem[rd_ptr];
            pop_log[pop_cnt] <= fifo_mem[rd_ptr];
            rd_ptr           <= rd_ptr + 1;
            pop_cnt          <= pop_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    bit  m_locked = 0;
    int  m_dir    = 0;
    bit  m_busy   = 0;

    function automatic int xy_ref(input int dx, input int dy);
        if (dx > MX) return 2;        // E
        if (dx < MX) return 0;        // W
        if (dy > MY) return 1;        // S
        if (dy < MY) return 3;        // N
        return 4;                     // L
    endfunction

    task automatic model_flit(input logic [DW-1:0] f);
        bit head, tail;
        int dx, dy;
        head = f[HEAD_BIT];
        tail = f[TAIL_BIT];
        dx   = int'(f[DST_LSB +: CW]);
        dy   = int'(f[DST_LSB + CW +: CW]);
        if (head) begin
            m_dir    = xy_ref(dx, dy);
            m_locked = 1;
            m_busy   = !tail;
            exp_q.push_back({1'b0, m_busy, 3'(m_dir), f});
        end else if (m_locked) begin
            exp_q.push_back({1'b0, m_busy, 3'(m_dir), f});
        end else begin
            exp_q.push_back({1'b1, 1'b0, 3'd0, f});
        end
        if ((head || m_locked) && tail) begin
            m_locked = 0;
            m_busy   = 0;
        end
    endtask

    int cyc = 0;
    int rd_rise_cyc[$];
    int outr_rise_cyc[$];
    int n_drop = 0;

    task automatic monitor_loop();
        int            seen_cnt;
        logic [4:0]    prev_outr, held_outr, exp_oh;
        logic          prev_drop, prev_rdreq;
        logic [DW-1:0] held_data;
        logic [EW-1:0] e;
        seen_cnt = 0; prev_outr = '0; held_outr = '0;
        prev_drop = 0; prev_rdreq = 0; held_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                exp_q.delete();
                m_locked = 0;
                m_busy   = 0;
                seen_cnt = pop_cnt;
                prev_outr = '0; prev_drop = 0; prev_rdreq = 0;
            end else begin
                while (seen_cnt < pop_cnt) begin
                    model_flit(pop_log[seen_cnt]);
                    seen_cnt++;
                end
                if (rdreq) begin
                    check("rdreq_one_cycle", prev_rdreq, 0);
                    if (!prev_rdreq) rd_rise_cyc.push_back(cyc);
                end
                if (outr_v != 0 && prev_outr == 0) begin
                    outr_rise_cyc.push_back(cyc);
                    check("outr_onehot", $countones(outr_v), 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_outr", outr_v, 0);
                    end else begin
                        e      = exp_q.pop_front();
                        exp_oh = 5'd1 << e[DW+2:DW];
                        check("not_drop", e[EW-1], 0);
                        check("outr_dir", outr_v, exp_oh);
                        check("dataout", DataOut, e[DW-1:0]);
                        check("busy_at_req", busy, e[DW+3]);
                    end
                    held_outr = outr_v;
                    held_data = DataOut;
                end else if (outr_v != 0) begin
                    check("outr_stable", outr_v, held_outr);
                    check("data_stable", DataOut, held_data);
                end
                if (drop) begin
                    n_drop++;
                    check("drop_one_cycle", prev_drop, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_drop", drop, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("drop_expected", e[EW-1], 1);
                    end
                end
                prev_outr  = outr_v;
                prev_drop  = drop;
                prev_rdreq = rdreq;
            end
        end
    endtask

    // ---------------- downstream responder ----------------
    bit ack_hold  = 0;
    int ack_delay = 0;   // <0: random 0..3
    bit rel_rand  = 0;

    task automatic responder_loop();
        bit waiting;
        int ack_cnt, cur_delay, rel_cnt;
        waiting = 0; ack_cnt = 0; cur_delay = 0; rel_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                outw_v  = '0;
                waiting = 0;
            end else if (outw_v != 0) begin
                if (outr_v == 0) begin
                    if (rel_cnt == 0) outw_v = '0;
                    else rel_cnt--;
                end
            end else if (outr_v != 0) begin
                if (!waiting) begin
                    waiting   = 1;
                    ack_cnt   = 0;
                    cur_delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                end
                if (!ack_hold) begin
                    if (ack_cnt >= cur_delay) begin
                        outw_v  = outr_v;
                        waiting = 0;
                        rel_cnt = rel_rand ? int'($urandom_range(0, 2)) : 0;
                    end else begin
                        ack_cnt++;
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [DW-1:0] mk_flit(input bit head, input bit tail, input int dx, input int dy);
        logic [DW-1:0] f;
        f[31:0]    = $urandom();
        f[DW-1:32] = 5'($urandom_range(0, 31));
        f[TAIL_BIT] = tail;
        f[HEAD_BIT] = head;
        f[DST_LSB +: CW]      = CW'(dx);
        f[DST_LSB + CW +: CW] = CW'(dy);
        return f;
    endfunction

    task automatic push(input logic [DW-1:0] f);
        fifo_mem[wr_ptr] = f;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_outr(input int budget);
        bool_seen: begin
            for (int i = 0; i < budget; i++) begin
                @(negedge clk); #1;
                if (outr_v != 0) disable bool_seen;
            end
            check("outr_timeout", 0, 1);
        end
    endtask

    task automatic drain(input int budget);
        int stable;
        stable = 0;
        for (int i = 0; i < budget && stable < 3; i++) begin
            @(negedge clk); #1;
            if (wr_ptr == rd_ptr && exp_q.size() == 0 && outr_v == 0 && outw_v == 0 &&
                dbg_state == ST_IDLE && !rdreq) stable++;
            else stable = 0;
        end
        if (stable < 3) check("drain_timeout", 0, 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int r0, o0, d0, p0;
        reset  = 1'b1;
        spur_n = 1'b0;
        fork
            monitor_loop();
            responder_loop();
        join_none

        repeat (3) @(negedge clk);
        #1;
        check("rst_rdreq", rdreq, 0);
        check("rst_outr", outr_v, 0);
        check("rst_dataout", DataOut, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(negedge clk); #1 reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single-flit packet to E, immediate ack.
        r0 = rd_rise_cyc.size(); o0 = outr_rise_cyc.size();
        push(mk_flit(1, 1, 2, 1));
        drain(200);
        check("t1_rdreq_pulses", rd_rise_cyc.size() - r0, 1);
        check("t1_handshakes", outr_rise_cyc.size() - o0, 1);
        check("t1_req_latency", outr_rise_cyc[o0] - rd_rise_cyc[r0], 2);
        check("t1_busy_after", busy, 0);

        // Back-to-back single flits: 5-cycle flit period.
        r0 = rd_rise_cyc.size();
        for (int i = 0; i < 3; i++) push(mk_flit(1, 1, 1, 1));
        drain(200);
        check("t1b_period_a", rd_rise_cyc[r0+1] - rd_rise_cyc[r0], 5);
        check("t1b_period_b", rd_rise_cyc[r0+2] - rd_rise_cyc[r0+1], 5);

        // Three-flit packet to S, ack delay 3.
        ack_delay = 3;
        o0 = outr_rise_cyc.size();
        push(mk_flit(1, 0, 1, 2));
        push(mk_flit(0, 0, $urandom_range(0, 3), $urandom_range(0, 3)));
        push(mk_flit(0, 1, $urandom_range(0, 3), $urandom_range(0, 3)));
        wait_outr(100);
        check("t2_busy_mid", busy, 1);
        drain(400);
        check("t2_handshakes", outr_rise_cyc.size() - o0, 3);
        check("t2_busy_after", busy, 0);
        ack_delay = 0;

        // Body flit while unlocked is dropped; next entry still served.
        d0 = n_drop; o0 = outr_rise_cyc.size();
        push(mk_flit(0, 0, 2, 2));
        push(mk_flit(1, 1, 2, 0));
        drain(200);
        check("t3_drops", n_drop - d0, 1);
        check("t3_handshakes", outr_rise_cyc.size() - o0, 1);

        // Local destination with a spurious N acknowledge during REQ.
        ack_hold = 1;
        push(mk_flit(1, 1, 1, 1));
        wait_outr(100);
        spur_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("t4_outr_l_held", outr_v, 5'b10000);
        check("t4_state_req", dbg_state, ST_REQ);
        spur_n = 1'b0;
        ack_hold = 0;
        drain(200);

        // Reset while Outr_W awaits ack; no residual lock afterwards.
        ack_hold = 1;
        push(mk_flit(1, 0, 0, 1));
        wait_outr(100);
        check("t5_outr_w", outr_v, 5'b00001);
        check("t5_busy_locked", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_outr_async", outr_v, 0);
        check("t5_busy_async", busy, 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        ack_hold = 0;
        d0 = n_drop; o0 = outr_rise_cyc.size();
        push(mk_flit(0, 1, 0, 1));
        push(mk_flit(1, 1, 1, 0));
        drain(200);
        check("t5_drop_after_rst", n_drop - d0, 1);
        check("t5_handshakes", outr_rise_cyc.size() - o0, 1);

        // Ack withheld 50 cycles while the FIFO refills.
        ack_hold = 1;
        push(mk_flit(1, 1, 2, 2));
        wait_outr(100);
        p0 = pop_cnt;
        for (int i = 0; i < 3; i++) push(mk_flit(1, 1, $urandom_range(0, 3), $urandom_range(0, 3)));
        repeat (50) @(negedge clk);
        #1;
        check("t6_no_extra_pop", pop_cnt, p0);
        check("t6_outr_held", outr_v, 5'b00100);
        ack_hold = 0;
        drain(400);

        // Randomized traffic.
        ack_delay = -1;
        rel_rand  = 1;
        for (int i = 0; i < 250; i++) begin
            push(mk_flit($urandom_range(0, 1), $urandom_range(0, 9) < 4,
                         $urandom_range(0, 3), $urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(negedge clk);
            if (i % 50 == 49) drain(5000);
        end
        drain(5000);
        #1;
        check("final_busy", busy, m_busy);
        check("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/out_port_ctrl.md
# out_port_ctrl

Output-side scheduler for one router node of the 2x2 NoC. It drains the shared per-node input FIFO filled by the five-way input arbiter and decodes the XY destination of each packet's head flit. It locks the chosen output link (W/S/E/N/L) for the whole packet and forwards flits one at a time over the same four-phase req/ack link handshake used on router inputs. The lock is released on the tail flit, giving wormhole switching.

## Interface
- DATA_WIDTH, 37: flit width.
- COORD_W, 1: width of each destination coordinate field.
- MY_X, 0: this node's X coordinate.
- MY_Y, 0: this node's Y coordinate.

- clk  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- empty  in  1  input FIFO empty flag.
- q  in  DATA_WIDTH  FIFO read data, valid on the cycle after an rdreq pulse.
- rdreq  out  1  FIFO pop, one-cycle pulse.
- DataOut  out  DATA_WIDTH  flit shared by all five output links; stable while any Outr is high.
- Outr_L, Outr_N, Outr_E, Outr_S, Outr_W  out  1 each  link request, at most one high.
- Outw_L, Outw_N, Outw_E, Outw_S, Outw_W  in  1 each  link acknowledge from the downstream input port.
- busy  out  1  high while a route is locked (head sent, tail not yet sent).
- drop  out  1  one-cycle pulse when a non-head flit is discarded while unlocked.

## Operation
- Flit fields: bit 4 = tail, bit 5 = head, dst_x = q[6 +: COORD_W], dst_y = q[6+COORD_W +: COORD_W]. A flit with head=1 and tail=1 is a single-flit packet.
- Direction index: W=0, S=1, E=2, N=3, L=4.
- XY routing is applied to head flits only:
  - dst_x>MY_X → E; dst_x<MY_X → W.
  - Else dst_y>MY_Y → S; dst_y<MY_Y → N.
  - Else L.
  - Comparisons are unsigned.
- A head flit always re-routes, even when the current route is still locked; a missing tail is tolerated.
- Unlocked and not head: the flit is discarded, drop pulses, and the state returns to IDLE.
- FSM:
  - IDLE: if !empty, rdreq<=1 → READ.
  - READ: rdreq<=0 → LATCH.
  - LATCH: DataOut<=q; route/drop decision made; Outr_dir<=1 → REQ.
  - REQ: hold Outr_dir and DataOut until Outw_dir sampled 1; then Outr_dir<=0 → REL.
  - REL: wait for Outw_dir sampled 0 → IDLE. The lock clears here if the flit had tail=1.
- Only the Outw of the locked direction is observed; acks on other links are ignored.
- empty is sampled only in IDLE; changes in other states have no effect.
- All outputs are registered.

## Timing
- Reset values: rdreq=0, all Outr=0, DataOut=0, busy=0, drop=0, FSM=IDLE, lock cleared.
- Reset asserted mid-handshake drops Outr within the same cycle (async). The in-flight flit is lost and is not re-read.
- Sequence when !empty is sampled at edge k:
  - rdreq is high for cycle k..k+1.
  - q is captured at edge k+2.
  - Outr rises after edge k+2.
- Downstream acking in 1 cycle: Outw high at edge k+3, Outr low after k+3, Outw low at edge k+4, IDLE at k+4, next rdreq at k+5. Minimum flit period is 5 cycles.
- No backpressure timeout: REQ and REL wait indefinitely.
- busy rises with Outr of a head flit without tail, and falls on the REL→IDLE edge of the tail flit.

## Structure
- Shared package noc_pkg holds:
  - DATA_WIDTH.
  - TAIL_BIT=4, HEAD_BIT=5, DST_LSB=6.
  - The direction encoding DIR_W..DIR_L (0..4).
  - FSM state constants.
- The input arbiter uses the same TAIL_BIT and direction encoding.
- One sub-module, xy_route: combinational (dst_x, dst_y, MY_X, MY_Y) → 3-bit direction. It is reused by every node's controller.

## Test plan
- MY=(0,0), FIFO holds single flit head=1, tail=1, dst=(1,0), immediate ack → one rdreq pulse, Outr_E high exactly one handshake, DataOut equals the flit, busy stays 0.
- Three-flit packet to dst=(0,1) (head, body, tail), ack delay 3 cycles → three handshakes all on Outr_S. busy is high from head until the REL of the tail, then returns to 0.
- Body flit with head=0 while unlocked → drop pulses once, no Outr asserted, FSM back to IDLE, next FIFO entry processed.
- dst=(0,0) head → Outr_L. Spurious Outw_N asserted during REQ → ignored, Outr_L held.
- Reset asserted while Outr_W is high awaiting ack → Outr_W=0, busy=0 immediately. After release, the next flit is routed from IDLE with no residual lock.
- Ack withheld 50 cycles with FIFO refilled meanwhile → Outr and DataOut stable throughout, no extra rdreq.
